// File: rtl/fc_error_streamer.sv
// Captures an fc layer's forward output vector, reports argmax/max, then streams the error vector
// y[k] - onehot(label)[k] back into the fc layer's backprop input.
module fc_error_streamer #(
    parameter int unsigned NumOut   = 10,
    parameter int unsigned IdxWidth = 10,
    parameter logic [31:0] One      = 32'h0001_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                src_valid_i,
    input  logic [31:0]         src_data_i,
    input  logic [IdxWidth-1:0] src_idx_i,
    output logic                src_rdy_o,
    input  logic                label_valid_i,
    input  logic [IdxWidth-1:0] label_i,
    input  logic                discard_i,
    input  logic                fc_rdy_i,
    output logic                err_valid_o,
    output logic [31:0]         err_data_o,
    output logic [IdxWidth-1:0] err_idx_o,
    output logic                bwd_active_o,
    output logic                done_o,
    output logic [IdxWidth-1:0] argmax_o,
    output logic [31:0]         max_val_o,
    output logic                label_err_o,
    output logic                sent_o
);

    localparam int unsigned BufAw = (NumOut > 1) ? $clog2(NumOut) : 1;
    localparam logic [IdxWidth-1:0] LastIdx   = IdxWidth'(NumOut - 1);
    localparam logic [IdxWidth-1:0] NumOutIdx = IdxWidth'(NumOut);

    typedef enum logic [1:0] {
        StCollect,
        StHold,
        StSend
    } state_e;

    state_e              state_q;
    logic                src_rdy_q;
    logic                err_valid_q;
    logic [31:0]         err_data_q;
    logic [IdxWidth-1:0] err_idx_q;
    logic                done_q;
    logic [IdxWidth-1:0] argmax_q;
    logic [31:0]         max_val_q;
    logic                label_err_q;
    logic                sent_q;
    logic [IdxWidth-1:0] label_q;
    logic                first_q;
    logic [31:0]         run_max_q;
    logic [IdxWidth-1:0] run_idx_q;

    logic [31:0]         buf_q [NumOut];

    logic                src_accept;
    logic                src_last;
    logic                cand_wins;
    logic                label_ok;
    logic                xfer;
    logic [IdxWidth-1:0] err_k_d;
    logic [IdxWidth-1:0] err_lbl;
    logic [31:0]         err_word_d;

    always_comb begin
        src_accept = (state_q == StCollect) && src_rdy_q && src_valid_i && (src_idx_i < NumOutIdx);
        src_last   = src_accept && (src_idx_i == LastIdx);
        // Ties go to the lower index so out-of-order arrival still reports the lowest argmax.
        cand_wins  = first_q
                  || ($signed(src_data_i) > $signed(run_max_q))
                  || ((src_data_i == run_max_q) && (src_idx_i < run_idx_q));
        label_ok   = label_valid_i && (label_i < NumOutIdx);
        xfer       = err_valid_q && fc_rdy_i;
        // Word loaded next: index 0 on label accept, else the successor of the current word.
        err_k_d    = (state_q == StHold) ? '0 : err_idx_q + IdxWidth'(1);
        err_lbl    = (state_q == StHold) ? label_i : label_q;
        err_word_d = buf_q[err_k_d[BufAw-1:0]] - ((err_k_d == err_lbl) ? One : 32'h0);
    end

    always_ff @(posedge clk_i) begin
        if (src_accept) begin
            buf_q[src_idx_i[BufAw-1:0]] <= src_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StCollect;
            src_rdy_q   <= 1'b0;
            err_valid_q <= 1'b0;
            err_data_q  <= '0;
            err_idx_q   <= '0;
            done_q      <= 1'b0;
            argmax_q    <= '0;
            max_val_q   <= '0;
            label_err_q <= 1'b0;
            sent_q      <= 1'b0;
            label_q     <= '0;
            first_q     <= 1'b1;
            run_max_q   <= '0;
            run_idx_q   <= '0;
        end else begin
            done_q      <= 1'b0;
            label_err_q <= 1'b0;
            sent_q      <= 1'b0;
            unique case (state_q)
                StCollect: begin
                    src_rdy_q <= 1'b1;
                    if (src_accept) begin
                        first_q <= 1'b0;
                        if (cand_wins) begin
                            run_max_q <= src_data_i;
                            run_idx_q <= src_idx_i;
                        end
                    end
                    if (src_last) begin
                        state_q   <= StHold;
                        src_rdy_q <= 1'b0;
                        done_q    <= 1'b1;
                        first_q   <= 1'b1;
                        argmax_q  <= cand_wins ? src_idx_i : run_idx_q;
                        max_val_q <= cand_wins ? src_data_i : run_max_q;
                    end
                end
                StHold: begin
                    if (label_valid_i) begin
                        if (label_ok) begin
                            state_q     <= StSend;
                            label_q     <= label_i;
                            err_valid_q <= 1'b1;
                            err_idx_q   <= '0;
                            err_data_q  <= err_word_d;
                        end else begin
                            label_err_q <= 1'b1;
                        end
                    end else if (discard_i) begin
                        state_q   <= StCollect;
                        src_rdy_q <= 1'b1;
                    end
                end
                StSend: begin
                    if (xfer) begin
                        if (err_idx_q == LastIdx) begin
                            state_q     <= StCollect;
                            src_rdy_q   <= 1'b1;
                            err_valid_q <= 1'b0;
                            sent_q      <= 1'b1;
                        end else begin
                            err_idx_q  <= err_k_d;
                            err_data_q <= err_word_d;
                        end
                    end
                end
                default: begin
                    state_q <= StCollect;
                end
            endcase
        end
    end

    assign src_rdy_o    = src_rdy_q;
    assign err_valid_o  = err_valid_q;
    assign err_data_o   = err_data_q;
    assign err_idx_o    = err_idx_q;
    assign bwd_active_o = (state_q == StSend);
    assign done_o       = done_q;
    assign argmax_o     = argmax_q;
    assign max_val_o    = max_val_q;
    assign label_err_o  = label_err_q;
    assign sent_o       = sent_q;

endmodule

// File: tb/tb_fc_error_streamer.sv
// Bench for fc_error_streamer: directed vectors, a vector-level reference model and a per-cycle
// compare process on the error stream and capture results.
module tb_fc_error_streamer;

    localparam int unsigned NumOut   = 10;
    localparam int unsigned IdxWidth = 10;
    localparam logic [31:0] One      = 32'h0001_0000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                src_valid = 1'b0;
    logic [31:0]         src_data = '0;
    logic [IdxWidth-1:0] src_idx = '0;
    logic                src_rdy;
    logic                label_valid = 1'b0;
    logic [IdxWidth-1:0] label = '0;
    logic                discard = 1'b0;
    logic                fc_rdy = 1'b0;
    logic                err_valid;
    logic [31:0]         err_data;
    logic [IdxWidth-1:0] err_idx;
    logic                bwd_active;
    logic                done;
    logic [IdxWidth-1:0] argmax;
    logic [31:0]         max_val;
    logic                label_err;
    logic                sent;

    fc_error_streamer #(
        .NumOut  (NumOut),
        .IdxWidth(IdxWidth),
        .One     (One)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .src_valid_i  (src_valid),
        .src_data_i   (src_data),
        .src_idx_i    (src_idx),
        .src_rdy_o    (src_rdy),
        .label_valid_i(label_valid),
        .label_i      (label),
        .discard_i    (discard),
        .fc_rdy_i     (fc_rdy),
        .err_valid_o  (err_valid),
        .err_data_o   (err_data),
        .err_idx_o    (err_idx),
        .bwd_active_o (bwd_active),
        .done_o       (done),
        .argmax_o     (argmax),
        .max_val_o    (max_val),
        .label_err_o  (label_err),
        .sent_o       (sent)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl_y [NumOut];
    int          mdl_label = 0;
    logic [31:0] got [NumOut];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Two-pass argmax: find the largest signed value, then the lowest index holding it.
    function automatic int mdl_argmax();
        logic signed [31:0] best;
        best = mdl_y[0];
        for (int k = 1; k < NumOut; k++) begin
            if ($signed(mdl_y[k]) > best) best = mdl_y[k];
        end
        for (int k = 0; k < NumOut; k++) begin
            if (mdl_y[k] == best) return k;
        end
        return 0;
    endfunction

    function automatic logic [31:0] mdl_err(input int k);
        return mdl_y[k] - ((k == mdl_label) ? One : 32'h0);
    endfunction

    // Per-cycle compare against the model.
    initial begin
        int          exp_k = 0;
        int          xfers = 0;
        bit          stalled = 0;
        logic [31:0] st_idx = '0;
        logic [31:0] st_data = '0;
        int          b;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_k = 0;
                xfers = 0;
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("stall_valid", {31'b0, err_valid}, 32'd1);
                    check("stall_idx", {22'b0, err_idx}, st_idx);
                    check("stall_data", err_data, st_data);
                end
                stalled = 0;
                if (done) begin
                    b = mdl_argmax();
                    check("argmax", {22'b0, argmax}, b);
                    check("max_val", max_val, mdl_y[b]);
                end
                if (err_valid) begin
                    check("err_idx", {22'b0, err_idx}, exp_k);
                    check("err_data", err_data, (exp_k < NumOut) ? mdl_err(exp_k) : 32'hDEAD_BEEF);
                    check("bwd_active", {31'b0, bwd_active}, 32'd1);
                    if (fc_rdy) begin
                        exp_k++;
                        xfers++;
                    end else begin
                        stalled = 1;
                        st_idx = {22'b0, err_idx};
                        st_data = err_data;
                    end
                end
                if (sent) begin
                    check("sent_count", xfers, NumOut);
                    check("sent_err_valid", {31'b0, err_valid}, 32'd0);
                    exp_k = 0;
                    xfers = 0;
                end
            end
        end
    end

    task automatic send_word(input int idx, input logic [31:0] data);
        int n = 0;
        src_valid = 1'b1;
        src_idx = IdxWidth'(idx);
        src_data = data;
        @(negedge clk);
        while (!src_rdy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("src_rdy_wait", {31'b0, src_rdy}, 32'd1);
        @(posedge clk);
        #1;
        src_valid = 1'b0;
    endtask

    task automatic stream_vec();
        for (int k = 0; k < NumOut; k++) send_word(k, mdl_y[k]);
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd1);
        check("hold_src_rdy", {31'b0, src_rdy}, 32'd0);
    endtask

    task automatic label_strobe(input int l, input logic disc);
        @(posedge clk);
        #1;
        label_valid = 1'b1;
        label = IdxWidth'(l);
        discard = disc;
        @(posedge clk);
        #1;
        label_valid = 1'b0;
        discard = 1'b0;
    endtask

    task automatic run_send(input int l, input bit toggle, input logic disc, input int exp_cyc);
        int n = 0;
        bit seen = 0;
        for (int k = 0; k < NumOut; k++) got[k] = 32'hxxxx_xxxx;
        mdl_label = l;
        fc_rdy = 1'b1;
        label_strobe(l, disc);
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (err_valid && fc_rdy && err_idx < NumOut) got[err_idx[3:0]] = err_data;
            if (sent) begin
                seen = 1;
            end else begin
                @(posedge clk);
                #1;
                if (toggle) fc_rdy = ~fc_rdy;
            end
        end
        check("sent_cycle", n, exp_cyc);
        check("sent_src_rdy", {31'b0, src_rdy}, 32'd1);
        check("sent_bwd_low", {31'b0, bwd_active}, 32'd0);
    endtask

    task automatic discard_vec();
        @(posedge clk);
        #1;
        discard = 1'b1;
        @(posedge clk);
        #1;
        discard = 1'b0;
        @(negedge clk);
        check("discard_src_rdy", {31'b0, src_rdy}, 32'd1);
        check("discard_no_err", {31'b0, err_valid}, 32'd0);
    endtask

    task automatic load_t1();
        for (int k = 0; k < NumOut; k++) mdl_y[k] = k * 32'h0001_0000;
        mdl_y[3] = 32'h000A_0000;
    endtask

    initial begin
        int n;
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_src_rdy", {31'b0, src_rdy}, 32'd0);
        check("rst_err_valid", {31'b0, err_valid}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_argmax", {22'b0, argmax}, 32'd0);
        check("rst_max_val", max_val, 32'd0);
        check("rst_err_idx", {22'b0, err_idx}, 32'd0);
        check("rst_bwd", {31'b0, bwd_active}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_src_rdy", {31'b0, src_rdy}, 32'd1);

        // 1: capture with an out-of-range word first, which must be ignored
        load_t1();
        send_word(15, 32'h7FFF_0000);
        stream_vec();
        check("t1_argmax", {22'b0, argmax}, 32'd3);
        check("t1_max_val", max_val, 32'h000A_0000);

        // 2: full-rate backprop with label 3
        run_send(3, 1'b0, 1'b0, 11);
        check("t2_e0", got[0], 32'h0000_0000);
        check("t2_e3", got[3], 32'h0009_0000);
        check("t2_e9", got[9], 32'h0009_0000);

        // 3: same vector, fc_rdy toggling
        stream_vec();
        run_send(3, 1'b1, 1'b0, 20);
        check("t3_e3", got[3], 32'h0009_0000);

        // 4a: negative values with a tie -> lowest index
        for (int k = 0; k < NumOut; k++) mdl_y[k] = 32'hFFFF_0000;
        mdl_y[7] = 32'hFFFE_0000;
        stream_vec();
        check("t4a_argmax", {22'b0, argmax}, 32'd0);
        check("t4a_max_val", max_val, 32'hFFFF_0000);
        discard_vec();

        // 4b: all equal; label_valid together with discard must start backprop
        for (int k = 0; k < NumOut; k++) mdl_y[k] = 32'h0000_8000;
        stream_vec();
        check("t4b_argmax", {22'b0, argmax}, 32'd0);
        run_send(2, 1'b0, 1'b1, 11);
        check("t4b_e2", got[2], 32'hFFFF_8000);

        // 4c: signed comparison and wrap of the error subtraction
        for (int k = 0; k < NumOut; k++) mdl_y[k] = 32'hF000_0000;
        mdl_y[0] = 32'h8000_0000;
        mdl_y[5] = 32'h0000_0001;
        stream_vec();
        check("t4c_argmax", {22'b0, argmax}, 32'd5);
        check("t4c_max_val", max_val, 32'h0000_0001);
        run_send(0, 1'b0, 1'b0, 11);
        check("t4c_e0_wrap", got[0], 32'h7FFF_0000);

        // 5: out-of-range label, then discard
        for (int k = 0; k < NumOut; k++) mdl_y[k] = 32'h0000_0100 + k * 3;
        stream_vec();
        label_strobe(12, 1'b0);
        @(negedge clk);
        check("t5_label_err", {31'b0, label_err}, 32'd1);
        check("t5_bwd", {31'b0, bwd_active}, 32'd0);
        check("t5_src_rdy", {31'b0, src_rdy}, 32'd0);
        @(negedge clk);
        check("t5_label_err_pulse", {31'b0, label_err}, 32'd0);
        check("t5_no_err_valid", {31'b0, err_valid}, 32'd0);
        discard_vec();
        repeat (2) begin
            @(negedge clk);
            check("t5_idle_err_valid", {31'b0, err_valid}, 32'd0);
        end

        // 6: reset while streaming at err_idx 4
        load_t1();
        stream_vec();
        mdl_label = 5;
        fc_rdy = 1'b1;
        label_strobe(5, 1'b0);
        n = 0;
        @(negedge clk);
        while (!(err_valid && err_idx == 4) && n < 30) begin
            n++;
            @(negedge clk);
        end
        check("t6_reach_idx4", {22'b0, err_idx}, 32'd4);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6_err_valid", {31'b0, err_valid}, 32'd0);
        check("t6_err_idx", {22'b0, err_idx}, 32'd0);
        check("t6_bwd", {31'b0, bwd_active}, 32'd0);
        check("t6_sent", {31'b0, sent}, 32'd0);
        check("t6_src_rdy_rst", {31'b0, src_rdy}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_src_rdy_after", {31'b0, src_rdy}, 32'd1);

        // Recovery: a fresh vector and full backprop after the abort
        for (int k = 0; k < NumOut; k++) mdl_y[k] = 32'h0002_0000 - k * 32'h0000_8000;
        stream_vec();
        check("rec_argmax", {22'b0, argmax}, 32'd0);
        run_send(9, 1'b0, 1'b0, 11);
        check("rec_e9", got[9], 32'hFFFC_8000);

        fc_rdy = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
